// File: rtl/mux_prio_stream_ls_if.sv
// Stream bundle for the priority mux: N_IN source-side channels in, one registered
// beat out. master = producers/consumer side, slave = the mux itself.
interface mux_prio_stream_ls_if #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_last;
    logic [N_IN-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;
    logic                  locked;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel, locked
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel, locked
    );
endinterface

// File: rtl/mux_prio_stream_ls.sv
// N_IN-way highest-index-wins stream mux with a registered output stage and an
// optional packet lock that keeps a multi-beat packet from being interleaved.
module mux_prio_stream_ls #(
    parameter int N_IN    = 4,
    parameter int WIDTH   = 8,
    parameter int LOCK_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    mux_prio_stream_ls_if.slave bus
);
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [WIDTH-1:0] chan_data [N_IN];
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [SEL_W-1:0] out_sel_reg;

    logic             lock_active;
    logic [SEL_W-1:0] lock_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic             xfer;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic [N_IN-1:0]  ready_vec;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
        assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end

    assign load = !out_valid_reg || bus.out_ready;

    // While locked only the owning channel may be served, even if it idles.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (lock_active) begin
            grant_idx   = lock_idx;
            grant_valid = bus.in_valid[lock_idx];
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.in_valid[i]) begin
                    grant_idx   = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign xfer     = !rst && load && grant_valid;
    assign sel_data = chan_data[grant_idx];
    assign sel_last = bus.in_last[grant_idx];

    always_comb begin
        ready_vec = '0;
        if (xfer) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign bus.in_ready = ready_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_sel_reg   <= '0;
        end else if (load) begin
            if (xfer) begin
                out_data_reg  <= sel_data;
                out_last_reg  <= sel_last;
                out_sel_reg   <= grant_idx;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    if (LOCK_EN != 0) begin : g_lock
        typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
        state_t           state_reg;
        logic [SEL_W-1:0] lock_idx_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg    <= ST_IDLE;
                lock_idx_reg <= '0;
            end else if (xfer) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!sel_last) begin
                            state_reg    <= ST_LOCKED;
                            lock_idx_reg <= grant_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_last) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end

        assign lock_active = (state_reg == ST_LOCKED);
        assign lock_idx    = lock_idx_reg;
    end else begin : g_nolock
        assign lock_active = 1'b0;
        assign lock_idx    = '0;
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.locked    = lock_active;
endmodule

// File: tb/tb_mux_prio_stream_ls.sv
// Random-stimulus scoreboard bench: a locking and a non-locking mux share the same
// inputs; a queue-based reference predicts every delivered beat for each.
module tb_mux_prio_stream_ls;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N*W-1:0] in_data  = '0;
    logic [N-1:0] in_valid = '0;
    logic [N-1:0] in_last  = '0;
    logic         out_ready = 1'b0;

    always #5 clk = ~clk;

    mux_prio_stream_ls_if #(.N_IN(N), .WIDTH(W)) ifa ();
    mux_prio_stream_ls_if #(.N_IN(N), .WIDTH(W)) ifb ();

    assign ifa.in_data = in_data;   assign ifb.in_data = in_data;
    assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
    assign ifa.in_last = in_last;   assign ifb.in_last = in_last;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    mux_prio_stream_ls #(.N_IN(N), .WIDTH(W), .LOCK_EN(1)) dut_lock (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mux_prio_stream_ls #(.N_IN(N), .WIDTH(W), .LOCK_EN(0)) dut_nolock (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic [1:0]   s;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t bm0, bm1;
    int total = 0;
    int bad   = 0;
    int ov[2];
    int lck[2];
    bit prev_rst;

    task automatic check(input string name, input int unit, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s unit=%0d got=%0h expected=%0h", name, unit, act, exp);
        end
    endtask

    // Monitors: every accepted output beat must match the oldest predicted beat.
    always @(negedge clk) begin
        if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL beat unit=0 got=%0h expected=none", ifa.out_data);
            end else begin
                bm0 = q0.pop_front();
                check("data", 0, 32'(ifa.out_data), 32'(bm0.d));
                check("last", 0, 32'(ifa.out_last), 32'(bm0.l));
                check("sel", 0, 32'(ifa.out_sel), 32'(bm0.s));
                $display("beat unit=0 data=%02h last=%0b sel=%0d", ifa.out_data, ifa.out_last, ifa.out_sel);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL beat unit=1 got=%0h expected=none", ifb.out_data);
            end else begin
                bm1 = q1.pop_front();
                check("data", 1, 32'(ifb.out_data), 32'(bm1.d));
                check("last", 1, 32'(ifb.out_last), 32'(bm1.l));
                check("sel", 1, 32'(ifb.out_sel), 32'(bm1.s));
                $display("beat unit=1 data=%02h last=%0b sel=%0d", ifb.out_data, ifb.out_last, ifb.out_sel);
            end
        end
    end

    task automatic step(input bit do_rst, input int p_ready, input int p_valid, input int p_last);
        logic [N-1:0] exp_ready;
        logic [N-1:0] act_ready;
        logic [N-1:0] one;
        logic [W-1:0] act_data;
        logic [1:0]   act_sel;
        logic         act_ov, act_lk;
        bit           load;
        int           g;
        beat_t        b;
        @(posedge clk);
        #1;
        rst       = do_rst;
        out_ready = do_rst ? 1'b0 : ($urandom_range(99) < p_ready);
        for (int c = 0; c < N; c++) begin
            in_valid[c]       = ($urandom_range(99) < p_valid);
            in_last[c]        = ($urandom_range(99) < p_last);
            in_data[c*W +: W] = W'($urandom);
        end
        #3;
        one = 4'b0001;
        for (int u = 0; u < 2; u++) begin
            act_ready = (u == 0) ? ifa.in_ready : ifb.in_ready;
            act_ov    = (u == 0) ? ifa.out_valid : ifb.out_valid;
            act_lk    = (u == 0) ? ifa.locked : ifb.locked;
            act_data  = (u == 0) ? ifa.out_data : ifb.out_data;
            act_sel   = (u == 0) ? ifa.out_sel : ifb.out_sel;
            if (prev_rst) begin
                check("sel_after_rst", u, 32'(act_sel), 32'd0);
                check("data_after_rst", u, 32'(act_data), 32'd0);
            end
            load = (ov[u] == 0) || out_ready;
            g = -1;
            if (!rst) begin
                if (lck[u] >= 0) begin
                    if (in_valid[lck[u]]) g = lck[u];
                end else begin
                    for (int c = 0; c < N; c++) if (in_valid[c]) g = c;
                end
            end
            exp_ready = (load && g >= 0) ? (one << g) : '0;
            check("in_ready", u, 32'(act_ready), 32'(exp_ready));
            check("out_valid", u, 32'(act_ov), 32'(ov[u]));
            check("locked", u, 32'(act_lk), (lck[u] >= 0) ? 32'd1 : 32'd0);
            if (rst) begin
                ov[u] = 0;
                lck[u] = -1;
                if (u == 0) q0.delete(); else q1.delete();
            end else if (load && g >= 0) begin
                b.d = in_data[g*W +: W];
                b.l = in_last[g];
                b.s = 2'(g);
                if (u == 0) q0.push_back(b); else q1.push_back(b);
                ov[u] = 1;
                if (u == 0) begin
                    if (lck[u] < 0 && !in_last[g]) lck[u] = g;
                    else if (lck[u] >= 0 && in_last[g]) lck[u] = -1;
                end
            end else if (load) begin
                ov[u] = 0;
            end
        end
        prev_rst = do_rst;
    endtask

    initial begin
        ov[0] = 0; ov[1] = 0;
        lck[0] = -1; lck[1] = -1;
        prev_rst = 1'b0;
        step(1'b1, 0, 50, 50);
        step(1'b1, 0, 50, 50);
        @(posedge clk);
        #1;
        check("rst_out_valid", 0, 32'(ifa.out_valid), 32'd0);
        check("rst_out_data", 0, 32'(ifa.out_data), 32'd0);
        check("rst_out_last", 0, 32'(ifa.out_last), 32'd0);
        check("rst_out_sel", 0, 32'(ifa.out_sel), 32'd0);
        check("rst_locked", 0, 32'(ifa.locked), 32'd0);
        check("rst_out_valid", 1, 32'(ifb.out_valid), 32'd0);
        prev_rst = 1'b0;
        for (int k = 0; k < 600; k++) step(1'b0, 100, 50, 40);
        for (int k = 0; k < 600; k++) step($urandom_range(99) < 1, 40, 60, 30);
        for (int k = 0; k < 400; k++) step($urandom_range(99) < 2, 70, 25, 50);
        for (int k = 0; k < 10; k++) step(1'b0, 100, 0, 0);
        check("drain_q0", 0, 32'(q0.size()), 32'd0);
        check("drain_q1", 1, 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_prio_stream_ls.md
Name: mux_prio_stream_ls

Overview:
- Parametrised successor of the 2:1 priority-select mux: N_IN-way priority multiplexer on valid/ready streams, with a registered output stage.
- Highest-index requesting channel wins, as the top select input overrides the lower pair today.
- Adds a packet lock mode so multi-beat transfers are not interleaved.
- Sits between source-side stream producers and a single downstream consumer.

Parameters:
N_IN, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
LOCK_EN, 1, 1 = hold grant from first beat until last beat; 0 = re-arbitrate every beat
SEL_W, $clog2(N_IN), width of out_sel (derived localparam, minimum 1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_IN  per-channel beat valid
in_last  input  N_IN  per-channel end-of-packet marker
in_ready  output  N_IN  per-channel accept (combinational)
out_data  output  WIDTH  registered selected data
out_valid  output  1  registered output valid
out_last  output  1  registered last marker of the held beat
out_sel  output  SEL_W  index of the channel that produced the held beat
out_ready  input  1  downstream accept
locked  output  1  grant is held mid-packet (LOCK_EN=1 only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0, internal lock index=0.
  - in_ready is all-zero while rst=1.
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Unlocked arbitration: grant = highest index i with in_valid[i]=1. No valid input means no grant.
- Locked (locked=1): grant = lock index only, regardless of other in_valid. If the locked channel deasserts valid, the block stalls; no other channel is served.
- in_ready[i] = load && granted && grant==i. At most one bit is set (one-hot or zero).
- Transfer on channel g when in_valid[g] && in_ready[g]. Next edge:
  - out_data <= in_data[g]
  - out_last <= in_last[g]
  - out_sel <= g
  - out_valid <= 1
- If load=1 and no transfer occurs: out_valid <= 0. out_data, out_last and out_sel keep their values.
- If load=0: all output registers hold.
- Latency: 1 cycle input-to-output. Full throughput of 1 beat/cycle with out_ready held high.
- Lock state machine (LOCK_EN=1). States:
  - IDLE: on a transfer with in_last[g]=0, go to LOCKED with lock index=g. A transfer with last=1 stays in IDLE (single-beat packet).
  - LOCKED: on a transfer with in_last=1, go to IDLE.
- locked=1 exactly in LOCKED.
- LOCK_EN=0: the FSM is absent and in_last is only passed through.
- Simultaneous events: out_ready=1 with a new transfer in the same cycle replaces the held beat. No bubble, no duplicate.
- Reset mid-packet: lock is cleared and the held beat is discarded (out_valid=0). The next cycle arbitrates freshly.
- Input data and last are sampled only on transfer. Changes while not granted are ignored.

Test Plan:
- Priority: N_IN=4, WIDTH=8, out_ready=1. in_valid=4'b0111, data ch0..2 = 0x10/0x20/0x30, all last=1 -> in_ready=4'b0100; next cycle out_data=0x30, out_sel=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0, in_valid[3]=1 -> in_ready=0; out_data holds for 5 cycles. Raise out_ready -> ch3 beat loads next edge, and only one transfer is counted.
- Lock: ch1 sends 3 beats 0xA1,0xA2,0xA3 (last on third). ch3 asserts valid at beat 2 -> ch3 not granted until after 0xA3 transfers; locked=1 for 2 cycles. Then ch3 is served.
- Lock stall: locked to ch0, ch0 drops valid for 2 cycles while ch2 is valid -> in_ready=0 and out_valid goes 0. ch0 resumes -> continues its packet.
- LOCK_EN=0: same stimulus as the Lock scenario -> ch3 beat interleaves at beat 2 (highest priority); locked stays 0.
- Reset mid-packet: assert rst for 1 cycle during LOCKED with out_valid=1 -> out_valid=0, locked=0, out_sel=0. The following cycle, the highest valid channel is granted.
